pfd_cp: RTL and testbench

PFD_CP -- requirements
Module: pfd_cp

---
 rtl/pfd_cp_pkg.sv | 21 ++
 rtl/pfd_cp_edge_sync.sv | 36 +++
 rtl/pfd_cp.sv | 137 +++++++++++++
 tb/tb_pfd_cp.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pfd_cp_pkg.sv
// Shared constants and pump-state encoding for the PFD / charge-pump block.
package pfd_cp_pkg;

    localparam real VDD_V = 3.0;

    localparam int W_DEF        = 16;
    localparam int I_STEP_DEF   = 64;
    localparam int LOCK_TOL_DEF = 2;
    localparam int LOCK_CNT_DEF = 8;
    localparam logic [15:0] V_INIT_DEF = 16'h8000;

    localparam int PW_BITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        PUMP_UP,
        PUMP_DN,
        CLEAR
    } pump_state_t;

endpackage

// File: rtl/pfd_cp_edge_sync.sv
// Two-flop synchronizer plus rising-edge detector for an asynchronous clock input.
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic       s1;
    logic       s2;
    logic       prev;
    logic       armed;
    logic [1:0] fill;

    // armed only after a real low has crossed the synchronizer, so an input
    // already high at reset release never produces a phantom edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            prev  <= 1'b0;
            armed <= 1'b0;
            fill  <= 2'b00;
        end else begin
            s1   <= din;
            s2   <= s1;
            prev <= s2;
            fill <= {fill[0], 1'b1};
            if (fill[1] && !s2)
                armed <= 1'b1;
        end
    end

    assign rise = armed & s2 & ~prev;

endmodule

// File: rtl/pfd_cp.sv
// Tri-state phase/frequency detector with saturating charge pump and lock detect.
module pfd_cp
    import pfd_cp_pkg::*;
#(
    parameter int W        = W_DEF,
    parameter int I_STEP   = I_STEP_DEF,
    parameter logic [W-1:0] V_INIT = W'(V_INIT_DEF),
    parameter int LOCK_TOL = LOCK_TOL_DEF,
    parameter int LOCK_CNT = LOCK_CNT_DEF
) (
    input  logic         refclk,
    input  logic         rst,
    input  logic         d,
    input  logic         ref_in,
    input  logic         fb_in,
    output logic         up,
    output logic         down,
    output logic [W-1:0] vout,
    output logic         lock
);

    localparam int AW = $clog2(LOCK_CNT + 1);
    localparam logic [AW-1:0]      CNT   = AW'(LOCK_CNT);
    localparam logic [PW_BITS-1:0] TOL   = PW_BITS'(LOCK_TOL);
    localparam logic [PW_BITS-1:0] PWMAX = '1;
    localparam logic [W:0]         STEP  = (W + 1)'(I_STEP);
    localparam logic [W:0]         VMAXE = {1'b0, {W{1'b1}}};

    logic ref_e;
    logic fb_e;

    edge_sync u_ref (
        .clk  (refclk),
        .rst  (rst),
        .din  (ref_in),
        .rise (ref_e)
    );

    edge_sync u_fb (
        .clk  (refclk),
        .rst  (rst),
        .din  (fb_in),
        .rise (fb_e)
    );

    pump_state_t state;
    pump_state_t state_n;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    // edges in the CLEAR cycle are dropped; simultaneous edges from IDLE stay IDLE
    always_comb begin
        state_n = state;
        if (!d) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (ref_e && !fb_e)
                        state_n = PUMP_UP;
                    else if (fb_e && !ref_e)
                        state_n = PUMP_DN;
                end
                PUMP_UP: if (fb_e)  state_n = CLEAR;
                PUMP_DN: if (ref_e) state_n = CLEAR;
                CLEAR:   state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    assign up   = (state == PUMP_UP) || (state == CLEAR);
    assign down = (state == PUMP_DN) || (state == CLEAR);

    logic [W:0]   vext;
    logic [W:0]   vsum;
    logic [W-1:0] vout_n;

    assign vext = {1'b0, vout};
    assign vsum = vext + STEP;

    always_comb begin
        vout_n = vout;
        unique case (1'b1)
            (d && up && !down):
                vout_n = (vsum > VMAXE) ? VMAXE[W-1:0] : vsum[W-1:0];
            (d && down && !up):
                vout_n = (vext < STEP) ? '0 : vout - STEP[W-1:0];
            default:
                vout_n = vout;
        endcase
    end

    logic [PW_BITS-1:0] width;
    logic [PW_BITS-1:0] width_n;
    logic [AW-1:0]      aligned;
    logic [AW-1:0]      aligned_n;
    logic [AW-1:0]      aligned_inc;

    assign aligned_inc = (aligned == CNT) ? aligned : aligned + 1'b1;

    always_comb begin
        width_n   = width;
        aligned_n = aligned;
        if (!d) begin
            width_n   = '0;
            aligned_n = '0;
        end else if (up || down) begin
            width_n = (width == PWMAX) ? width : width + 1'b1;
        end else if (width != '0) begin
            width_n   = '0;
            aligned_n = (width <= TOL) ? aligned_inc : '0;
        end else if (ref_e && fb_e) begin
            aligned_n = aligned_inc;
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            vout    <= V_INIT;
            width   <= '0;
            aligned <= '0;
            lock    <= 1'b0;
        end else begin
            vout    <= vout_n;
            width   <= width_n;
            aligned <= aligned_n;
            lock    <= d && (aligned_n == CNT);
        end
    end

endmodule

// File: tb/tb_pfd_cp.sv
// Scoreboard bench for pfd_cp: expected pump/lock results queued per stimulus.
module tb_pfd_cp;

    logic        refclk = 1'b0;
    logic        rst;
    logic        d;
    logic        ref_in;
    logic        fb_in;
    logic        up;
    logic        down;
    logic        lock;
    logic [15:0] vout;

    pfd_cp dut (
        .refclk (refclk),
        .rst    (rst),
        .d      (d),
        .ref_in (ref_in),
        .fb_in  (fb_in),
        .up     (up),
        .down   (down),
        .vout   (vout),
        .lock   (lock)
    );

    always #5 refclk = ~refclk;

    typedef struct {
        int v;
        int upc;
        int dnc;
        int both;
        bit lk;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    int checks   = 0;
    int failures = 0;
    int mv;
    int al;

    int o_upc, o_dnc, o_both, o_last, o_fall, o_vmax, o_vmin;
    bit o_lock0;

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    // bench reference model: pump result and aligned-comparison counter
    function automatic int vmodel(input int v, input int lead);
        int r;
        r = v + lead * 64;
        if (r > 65535) r = 65535;
        if (r < 0) r = 0;
        return r;
    endfunction

    task automatic push_exp(input int lead);
        exp_t x;
        int   w;
        mv = vmodel(mv, lead);
        w  = (lead == 0) ? 0 : iabs(lead) + 1;
        if (w <= 2) al = (al < 8) ? al + 1 : 8;
        else        al = 0;
        x.v    = mv;
        x.upc  = (lead > 0) ? lead : 0;
        x.dnc  = (lead < 0) ? -lead : 0;
        x.both = (lead != 0) ? 1 : 0;
        x.lk   = (al == 8);
        sb.push_back(x);
    endtask

    task automatic run_pair(input int lead);
        int rs, fs, h, t;
        rs = (lead < 0) ? -lead : 0;
        fs = (lead > 0) ? lead : 0;
        h  = iabs(lead) + 4;
        t  = iabs(lead) + h + 14;
        o_upc = 0; o_dnc = 0; o_both = 0;
        o_last = -1; o_fall = -1;
        o_vmax = 0; o_vmin = 65535;
        for (int c = 0; c < t; c++) begin
            @(negedge refclk);
            if (c == 0) o_lock0 = lock;
            if (up && !down) o_upc++;
            if (down && !up) o_dnc++;
            if (up && down) o_both++;
            if (up || down) o_last = c;
            if (o_lock0 && !lock && o_fall < 0) o_fall = c;
            if (int'(vout) > o_vmax) o_vmax = int'(vout);
            if (int'(vout) < o_vmin) o_vmin = int'(vout);
            ref_in = (c >= rs) && (c < rs + h);
            fb_in  = (c >= fs) && (c < fs + h);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; d = 1'b1; ref_in = 1'b0; fb_in = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge refclk);
            ref_in = c[0];
            fb_in  = ~c[0];
            checks++;
            if ({up, down, lock} !== 3'b000 || vout !== 16'h8000) begin
                failures++;
                $display("FAIL reset c=%0d: up=%b down=%b lock=%b vout=%h want 0 0 0 8000",
                         c, up, down, lock, vout);
            end
        end
    endtask

    task automatic test_release_high;
        int seen;
        seen = 0;
        @(negedge refclk);
        ref_in = 1'b1; fb_in = 1'b0;
        @(negedge refclk);
        rst = 1'b0;
        repeat (10) begin
            @(negedge refclk);
            if (up || down) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL release_high: pump cycles=%0d want 0", seen);
        end
        ref_in = 1'b0;
        repeat (6) @(negedge refclk);
    endtask

    task automatic test_ref_lead;
        push_exp(10);
        run_pair(10);
        e = sb.pop_front();
        checks++;
        if (o_upc != e.upc || o_dnc != e.dnc || o_both != e.both) begin
            failures++;
            $display("FAIL ref_lead pulses: up=%0d dn=%0d both=%0d want %0d %0d %0d",
                     o_upc, o_dnc, o_both, e.upc, e.dnc, e.both);
        end
        checks++;
        if (int'(vout) != e.v || lock !== e.lk) begin
            failures++;
            $display("FAIL ref_lead vout/lock: vout=%0d lock=%b want %0d %b",
                     vout, lock, e.v, e.lk);
        end
    endtask

    task automatic test_fb_lead;
        push_exp(-5);
        run_pair(-5);
        e = sb.pop_front();
        checks++;
        if (o_upc != e.upc || o_dnc != e.dnc || o_both != e.both) begin
            failures++;
            $display("FAIL fb_lead pulses: up=%0d dn=%0d both=%0d want %0d %0d %0d",
                     o_upc, o_dnc, o_both, e.upc, e.dnc, e.both);
        end
        checks++;
        if (int'(vout) != e.v) begin
            failures++;
            $display("FAIL fb_lead vout: got %0d want %0d", vout, e.v);
        end
    endtask

    task automatic test_zero_phase;
        for (int k = 0; k < 8; k++) begin
            push_exp(0);
            run_pair(0);
            e = sb.pop_front();
            checks++;
            if (o_upc + o_dnc + o_both != 0 || o_vmax != e.v || o_vmin != e.v) begin
                failures++;
                $display("FAIL zero_phase k=%0d: pump=%0d vmin=%0d vmax=%0d want 0 %0d",
                         k, o_upc + o_dnc + o_both, o_vmin, o_vmax, e.v);
            end
            checks++;
            if (lock !== e.lk) begin
                failures++;
                $display("FAIL zero_phase_lock k=%0d: got %b want %b", k, lock, e.lk);
            end
        end
    endtask

    task automatic test_lock_loss;
        push_exp(6);
        run_pair(6);
        e = sb.pop_front();
        checks++;
        if (!o_lock0 || lock !== e.lk) begin
            failures++;
            $display("FAIL lock_loss: lock_before=%b lock_after=%b want 1 %b",
                     o_lock0, lock, e.lk);
        end
        checks++;
        if (o_fall != o_last + 2) begin
            failures++;
            $display("FAIL lock_loss_timing: fall=%0d want %0d", o_fall, o_last + 2);
        end
        checks++;
        if (int'(vout) != e.v) begin
            failures++;
            $display("FAIL lock_loss vout: got %0d want %0d", vout, e.v);
        end
    endtask

    task automatic test_underflow;
        int v0;
        for (int k = 0; k < 3; k++) begin
            v0 = int'(vout);
            push_exp(-200);
            run_pair(-200);
            e = sb.pop_front();
            checks++;
            if (int'(vout) != e.v || o_vmax > v0 || o_dnc != e.dnc) begin
                failures++;
                $display("FAIL underflow k=%0d: vout=%0d vmax=%0d dn=%0d want %0d <=%0d %0d",
                         k, vout, o_vmax, o_dnc, e.v, v0, e.dnc);
            end
        end
    endtask

    task automatic test_enable;
        int  v0;
        int  bad;
        bit  lk0;
        v0 = mv; bad = 0; lk0 = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge refclk);
            if (c == 0) lk0 = lock;
            if (c == 3) begin
                checks++;
                if (up !== 1'b1) begin
                    failures++;
                    $display("FAIL enable_up_start: up=%b want 1", up);
                end
            end
            if (c == 6) begin
                checks++;
                if (up !== 1'b0 || lock !== 1'b0 || !lk0) begin
                    failures++;
                    $display("FAIL enable_off: up=%b lock=%b lock_before=%b want 0 0 1",
                             up, lock, lk0);
                end
            end
            if (c >= 6 && int'(vout) != v0 + 128) bad++;
            ref_in = (c < 12);
            fb_in  = (c >= 8) && (c < 12);
            d      = !((c >= 5) && (c < 25));
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL enable_freeze: off-cycles with vout!=%0d: %0d", v0 + 128, bad);
        end
        mv = v0 + 128;
        al = 0;
        push_exp(3);
        run_pair(3);
        e = sb.pop_front();
        checks++;
        if (int'(vout) != e.v || o_upc != e.upc || lock !== e.lk) begin
            failures++;
            $display("FAIL enable_resume: vout=%0d up=%0d lock=%b want %0d %0d %b",
                     vout, o_upc, lock, e.v, e.upc, e.lk);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge refclk);
        ref_in = 1'b1;
        repeat (5) @(negedge refclk);
        checks++;
        if (up !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_pre: up=%b want 1", up);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (up !== 1'b0 || vout !== 16'h8000 || lock !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: up=%b vout=%h lock=%b want 0 8000 0", up, vout, lock);
        end
        @(negedge refclk);
        ref_in = 1'b0;
        rst = 1'b0;
        repeat (4) @(negedge refclk);
    endtask

    initial begin
        mv = 32768;
        al = 0;
        test_reset;
        test_release_high;
        test_ref_lead;
        test_fb_lead;
        test_zero_phase;
        test_lock_loss;
        test_underflow;
        test_zero_phase;
        test_enable;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
